// File: rtl/rec_pkg.sv
// Shared state encodings and default widths for the record/playback buffer.
package rec_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RECORD = 2'd1,
      ST_PLAY   = 2'd2
   } state_e;

   localparam int unsigned REC_DATA_W = 16;
   localparam int unsigned REC_ADDR_W = 14;

endpackage

// File: rtl/rec_ram.sv
// Simple dual-port sample store: one write port, one registered read port
// with enable and synchronous output clear.
module rec_ram #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned ADDR_W = 14
) (
   input  logic              clk_i,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic              rd_en_i,
   input  logic              rd_rst_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic [DATA_W-1:0] rd_data_o
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rd_data_q;

   always_ff @(posedge clk_i) begin
      if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
   end

   always_ff @(posedge clk_i) begin
      if (rd_rst_i)     rd_data_q <= '0;
      else if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/rec_play_buffer.sv
// Record/playback sample buffer: IDLE/RECORD/PLAY FSM, pointers and output register.
// Define REC_PLAY_LOOP_EN to loop playback instead of stopping at the end.
module rec_play_buffer
   import rec_pkg::*;
#(
   parameter int unsigned DATA_W = REC_DATA_W,
   parameter int unsigned ADDR_W = REC_ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              record,
   input  logic              playback,
   input  logic              sample_end,
   input  logic              sample_req,
   input  logic [DATA_W-1:0] audio_input,
   output logic [DATA_W-1:0] audio_output,
   output logic [ADDR_W:0]   rec_len,
   output logic              full,
   output logic [1:0]        state
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   rec_len_q, rec_len_d;
   logic              full_q, full_d;
   logic [DATA_W-1:0] audio_q, audio_d;
   logic              rec_lock_q, rec_lock_d;
   logic              play_lock_q, play_lock_d;
   logic              wr_en, rd_en, last_sample;
   logic [DATA_W-1:0] prefetch;

   // Read address follows rd_ptr_d so the prefetch always holds mem[rd_ptr_q].
   rec_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
      .clk_i     (clk),
      .wr_en_i   (wr_en && !reset),
      .wr_addr_i (wr_ptr_q),
      .wr_data_i (audio_input),
      .rd_en_i   (rd_en),
      .rd_rst_i  (reset),
      .rd_addr_i (rd_ptr_d),
      .rd_data_o (prefetch)
   );

   assign last_sample = ({1'b0, rd_ptr_q} == (rec_len_q - 1'b1));

   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      rec_len_d   = rec_len_q;
      full_d      = full_q;
      audio_d     = audio_q;
      rec_lock_d  = rec_lock_q & record;
      play_lock_d = play_lock_q & playback;
      wr_en       = 1'b0;
      rd_en       = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            audio_d = '0;
            if (record && !rec_lock_q) begin
               state_d   = ST_RECORD;
               wr_ptr_d  = '0;
               rec_len_d = '0;
               full_d    = 1'b0;
            end else if (playback && !record && !play_lock_q && rec_len_q != '0) begin
               state_d  = ST_PLAY;
               rd_ptr_d = '0;
               rd_en    = 1'b1;
            end
         end
         ST_RECORD: begin
            audio_d = '0;
            if (!record) begin
               state_d = ST_IDLE;
            end else if (sample_end) begin
               wr_en     = 1'b1;
               wr_ptr_d  = wr_ptr_q + 1'b1;
               rec_len_d = rec_len_q + 1'b1;
               // Lock out re-entry until record is released after a full buffer.
               if (wr_ptr_q == LAST_ADDR) begin
                  full_d     = 1'b1;
                  state_d    = ST_IDLE;
                  rec_lock_d = 1'b1;
               end
            end
         end
         ST_PLAY: begin
            if (!playback) begin
               state_d = ST_IDLE;
               audio_d = '0;
            end else if (sample_req) begin
               audio_d = prefetch;
               rd_en   = 1'b1;
               if (last_sample) begin
`ifdef REC_PLAY_LOOP_EN
                  rd_ptr_d = '0;
`else
                  state_d     = ST_IDLE;
                  play_lock_d = 1'b1;
                  rd_en       = 1'b0;
`endif
               end else begin
                  rd_ptr_d = rd_ptr_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            audio_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         rec_len_q   <= '0;
         full_q      <= 1'b0;
         audio_q     <= '0;
         rec_lock_q  <= 1'b0;
         play_lock_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         rec_len_q   <= rec_len_d;
         full_q      <= full_d;
         audio_q     <= audio_d;
         rec_lock_q  <= rec_lock_d;
         play_lock_q <= play_lock_d;
      end
   end

   assign audio_output = audio_q;
   assign rec_len      = rec_len_q;
   assign full         = full_q;
   assign state        = state_q;

endmodule

// File: doc/rec_play_buffer.md
REC_PLAY_BUFFER -- requirements
Module: rec_play_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 16, audio sample width.
REQ-002 SHALL have parameter ADDR_W, default 14, buffer address width; depth = 2^ADDR_W samples.
REQ-003 SHALL have port clk, input, 1: audio clock; one clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high.
REQ-005 SHALL have port record, input, 1: level; request capture.
REQ-006 SHALL have port playback, input, 1: level; request replay.
REQ-007 SHALL have port sample_end, input, 1: one-cycle pulse; audio_input is valid this cycle.
REQ-008 SHALL have port sample_req, input, 1: one-cycle pulse; codec takes the next output sample.
REQ-009 SHALL have port audio_input, input, DATA_W: captured codec sample.
REQ-010 SHALL have port audio_output, output, DATA_W: sample to codec.
REQ-011 SHALL have port rec_len, output, ADDR_W+1: number of stored samples.
REQ-012 SHALL have port full, output, 1: buffer filled during the current or last recording.
REQ-013 SHALL have port state, output, 2: 0 IDLE, 1 RECORD, 2 PLAY.

Function
REQ-014 SHALL implement FSM IDLE/RECORD/PLAY; code 3 unused and SHALL return to IDLE.
REQ-015 IDLE->RECORD when record=1; record SHALL win over playback when both are high.
REQ-016 IDLE->PLAY when playback=1, record=0 and rec_len>0; if rec_len=0, SHALL stay IDLE.
REQ-017 Entering RECORD SHALL clear wr_ptr, rec_len and full.
REQ-018 In RECORD, each sample_end SHALL write audio_input to mem[wr_ptr], then increment wr_ptr and rec_len in the same cycle.
REQ-019 On the write to address 2^ADDR_W-1, SHALL set full=1, rec_len=2^ADDR_W, and go to IDLE next cycle.
REQ-020 RECORD->IDLE when record=0; rec_len SHALL hold the count; a sample_end in that same cycle SHALL be discarded.
REQ-021 Entering PLAY SHALL set rd_ptr=0 and issue a synchronous read of mem[0] into a prefetch register; the read SHALL complete in 1 cycle.
REQ-022 In PLAY, on sample_req: audio_output <= prefetch on the next edge; rd_ptr increments; mem[rd_ptr+1] is prefetched (1-cycle read latency).
REQ-023 Since sample_req pulses are >=2 cycles apart, prefetch SHALL always be valid at the next sample_req.
REQ-024 When the sample at rd_ptr=rec_len-1 is emitted, end-of-buffer behaviour SHALL follow REQ-031/REQ-032.
REQ-025 PLAY->IDLE when playback=0; audio_output SHALL become 0 next cycle.
REQ-026 In IDLE and RECORD, audio_output SHALL be 0 (monitoring is handled elsewhere).
REQ-027 Buffer contents SHALL NOT be cleared by any state change or by reset.

Reset
REQ-028 On reset=1 at a clock edge: state=IDLE, audio_output=0, rec_len=0, full=0, wr_ptr=0, rd_ptr=0, prefetch=0.
REQ-029 Reset mid-RECORD or mid-PLAY SHALL abort immediately; the next operation starts fresh per REQ-017/REQ-021.
REQ-030 Reset SHALL take priority over every other input.

Configuration
REQ-031 With macro REC_PLAY_LOOP_EN defined, after emitting sample rec_len-1, rd_ptr SHALL wrap to 0 and prefetch mem[0]; PLAY continues while playback=1.
REQ-032 Without it, after emitting sample rec_len-1 the block SHALL go to IDLE, and audio_output SHALL be 0 from the next sample_req until playback is re-asserted from IDLE.

Structure
REQ-033 Shared package rec_pkg SHALL hold state encodings (ST_IDLE, ST_RECORD, ST_PLAY) and default DATA_W/ADDR_W constants.
REQ-034 Storage SHALL be sub-module rec_ram: simple dual-port, one write port, one synchronous read port, 1-cycle latency, inferable as block RAM.
REQ-035 The FSM, pointers and output register SHALL live in rec_play_buffer.

Verification (ADDR_W=4, depth 16)
REQ-036 Record with 5 sample_end pulses (data 0x0001..0x0005), then drop record -> rec_len=5, full=0, state=IDLE.
REQ-037 Playback after REQ-036: 5 sample_req -> audio_output 0x0001..0x0005, each 1 cycle after its req; 6th req -> 0x0000 and state=IDLE (no loop) or 0x0001 (loop).
REQ-038 Record held through 20 sample_end pulses -> full=1, rec_len=16, state=IDLE after the 16th write; pulses 17-20 ignored.
REQ-039 record and playback both raised in IDLE -> state=RECORD; playback with rec_len=0 -> state stays IDLE.
REQ-040 Reset asserted after 3rd sample_req in PLAY -> next cycle state=IDLE, audio_output=0, rec_len=0; later record of 2 samples followed by playback returns the new samples.
REQ-041 sample_end coincident with record falling -> sample not stored; rec_len unchanged.
